// File: rtl/and_unit_arbiter.sv
// ============================================================================
// and_unit_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Four requesters share one N_BITS-wide AND datapath. A round-robin arbiter
//   picks one requester and captures its operand pair. The shared and_gate then
//   produces A & B. The result comes back registered, with a one-cycle Done
//   pulse and the winner's index.
//
//   Per-operation timeline (t = the cycle in which Req is sampled in IDLE):
//     t   : IDLE. The winner is chosen and its operands are captured on the edge.
//     t+1 : EXEC. Grant and Busy are visible. The and_gate output is registered.
//     t+2 : DONE. Done = 1. Result and Result_Id are valid.
//     t+3 : IDLE. A request that is still high here counts as a new request.
//
// Ports:
//   clk        in   1           system clock, rising edge
//   reset      in   1           synchronous, active-high reset
//   Req        in   4           request lines, bit i = requester i
//   A_Bus      in   4*N_BITS    operand A, requester i owns [i*N_BITS +: N_BITS]
//   B_Bus      in   4*N_BITS    operand B, same slicing as A_Bus
//   Grant      out  4           one-hot, registered, the requester being served
//   Busy       out  1           registered, high whenever the FSM is not IDLE
//   Result     out  N_BITS      registered A & B of the granted requester
//   Result_Id  out  2           registered index of the owner of Result
//   Done       out  1           registered one-cycle pulse
// ============================================================================

// ----------------------------------------------------------------------------
// and_gate: the shared bitwise AND datapath (c = a & b)
//   a  in  N_BITS   operand A
//   b  in  N_BITS   operand B
//   c  out N_BITS   bitwise AND
// ----------------------------------------------------------------------------
module and_gate #(
    parameter int N_BITS = 8
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] c
);

    generate
        for (genvar gi = 0; gi < N_BITS; gi++) begin : g_bit
            assign c[gi] = a[gi] & b[gi];
        end
    endgenerate

endmodule

// ----------------------------------------------------------------------------
// and_unit_arbiter: top level
// ----------------------------------------------------------------------------
module and_unit_arbiter #(
    parameter int N_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            Req,
    input  logic [4*N_BITS-1:0]   A_Bus,
    input  logic [4*N_BITS-1:0]   B_Bus,
    output logic [3:0]            Grant,
    output logic                  Busy,
    output logic [N_BITS-1:0]     Result,
    output logic [1:0]            Result_Id,
    output logic                  Done
);

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    logic [1:0]        state_reg,     state_next;
    logic [1:0]        last_reg,      last_next;
    logic [3:0]        grant_reg,     grant_next;
    logic              busy_reg,      busy_next;
    logic              done_reg,      done_next;
    logic [N_BITS-1:0] result_reg,    result_next;
    logic [1:0]        result_id_reg, result_id_next;
    logic [N_BITS-1:0] op_a_reg,      op_a_next;
    logic [N_BITS-1:0] op_b_reg,      op_b_next;

    // ------------------------------------------------------------------------
    // Split the flat operand buses into per-requester slices
    // ------------------------------------------------------------------------
    logic [N_BITS-1:0] a_slice [4];
    logic [N_BITS-1:0] b_slice [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            assign a_slice[gi] = A_Bus[gi*N_BITS +: N_BITS];
            assign b_slice[gi] = B_Bus[gi*N_BITS +: N_BITS];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin winner search. Candidates are checked in the order
    // last+1, last+2, last+3, last (mod 4), and the first active request wins.
    // The 2-bit add wraps naturally, so last = 3 starts the search at 0. The
    // fourth candidate (offset 4, which truncates to 0) lets a lone
    // persistent requester win again.
    // ------------------------------------------------------------------------
    logic       req_any;
    logic [1:0] winner;
    logic [3:0] winner_onehot;

    assign req_any = |Req;

    always_comb begin
        logic       found;
        logic [1:0] idx;
        found  = 1'b0;
        winner = last_reg;
        idx    = last_reg;
        for (int k = 1; k <= 4; k++) begin
            idx = last_reg + 2'(k);
            if (!found && Req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign winner_onehot[gi] = (winner == 2'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Shared datapath. It only ever sees the captured operand registers, so
    // bus activity after capture cannot disturb an operation in flight.
    // ------------------------------------------------------------------------
    logic [N_BITS-1:0] and_c;

    and_gate #(
        .N_BITS (N_BITS)
    ) u_and_gate (
        .a (op_a_reg),
        .b (op_b_reg),
        .c (and_c)
    );

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        last_next      = last_reg;
        grant_next     = grant_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        result_next    = result_reg;
        result_id_next = result_id_reg;
        op_a_next      = op_a_reg;
        op_b_next      = op_b_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_any) begin
                    grant_next     = winner_onehot;
                    op_a_next      = a_slice[winner];
                    op_b_next      = b_slice[winner];
                    result_id_next = winner;
                    last_next      = winner;
                    busy_next      = 1'b1;
                    state_next     = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // Req and the operand buses are ignored in this state.
                result_next = and_c;
                done_next   = 1'b1;
                state_next  = ST_DONE;
            end

            ST_DONE: begin
                // Result and Result_Id are kept until the next completion.
                done_next  = 1'b0;
                grant_next = 4'b0000;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end

            default: begin
                // Unreachable encoding: fall back to a clean idle condition.
                done_next  = 1'b0;
                grant_next = 4'b0000;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers. Reset overrides every transition and abandons any operation
    // in flight, so an aborted operation never produces a Done.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            last_reg      <= 2'd3;
            grant_reg     <= 4'b0000;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= '0;
            result_id_reg <= 2'd0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            grant_reg     <= grant_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            result_reg    <= result_next;
            result_id_reg <= result_id_next;
            op_a_reg      <= op_a_next;
            op_b_reg      <= op_b_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Grant     = grant_reg;
    assign Busy      = busy_reg;
    assign Result    = result_reg;
    assign Result_Id = result_id_reg;
    assign Done      = done_reg;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// ============================================================================
// tb_and_unit_arbiter
// ----------------------------------------------------------------------------
// Directed self-checking bench for and_unit_arbiter (N_BITS = 8).
// When a request is issued, the expected {id, result} is pushed to a
// scoreboard queue. It is popped and compared in the cycle where Done rises.
// ============================================================================
module tb_and_unit_arbiter;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     Req;
    logic [4*N-1:0] A_Bus;
    logic [4*N-1:0] B_Bus;
    logic [3:0]     Grant;
    logic           Busy;
    logic [N-1:0]   Result;
    logic [1:0]     Result_Id;
    logic           Done;

    typedef struct packed {
        logic [1:0]   id;
        logic [N-1:0] res;
    } exp_t;

    exp_t sb[$];

    int compared   = 0;
    int mismatched = 0;

    and_unit_arbiter #(.N_BITS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .Req       (Req),
        .A_Bus     (A_Bus),
        .B_Bus     (B_Bus),
        .Grant     (Grant),
        .Busy      (Busy),
        .Result    (Result),
        .Result_Id (Result_Id),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        A_Bus[i*N +: N] = a;
        B_Bus[i*N +: N] = b;
    endtask

    // Pop the scoreboard when Done is seen and compare. If Done is missing,
    // that is reported and the expectation is still retired, so the queue
    // stays aligned with later operations.
    task automatic check_done(input string tag, output exp_t e);
        check({tag, ".done"}, {31'd0, Done}, 32'd1);
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s.sb: observed empty scoreboard expected entry", tag);
            e = '0;
        end else begin
            e = sb.pop_front();
            check({tag, ".result"}, {24'd0, Result}, {24'd0, e.res});
            check({tag, ".id"}, {30'd0, Result_Id}, {30'd0, e.id});
        end
        $display("txn %s: id=%0d result=%02h done=%0b", tag, Result_Id, Result, Done);
    endtask

    // One complete operation starting in IDLE with Req already driven.
    // req_after is driven during the DONE cycle.
    task automatic serve(input string tag, input int id, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [3:0] req_after);
        exp_t e;
        sb.push_back('{id: 2'(id), res: a & b});
        tick();
        check({tag, ".grant"}, {28'd0, Grant}, 32'd1 << id);
        check({tag, ".busy1"}, {31'd0, Busy}, 32'd1);
        check({tag, ".nodone"}, {31'd0, Done}, 32'd0);
        tick();
        check_done(tag, e);
        Req = req_after;
        tick();
        check({tag, ".done0"}, {31'd0, Done}, 32'd0);
        check({tag, ".busy0"}, {31'd0, Busy}, 32'd0);
        check({tag, ".grant0"}, {28'd0, Grant}, 32'd0);
        check({tag, ".hold"}, {24'd0, Result}, {24'd0, e.res});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        Req   = 4'b0000;
        A_Bus = '0;
        B_Bus = '0;

        // Reset, then idle
        tick();
        tick();
        check("rst.grant", {28'd0, Grant}, 32'd0);
        check("rst.busy", {31'd0, Busy}, 32'd0);
        check("rst.done", {31'd0, Done}, 32'd0);
        check("rst.result", {24'd0, Result}, 32'd0);
        check("rst.id", {30'd0, Result_Id}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle.done", {31'd0, Done}, 32'd0);
            check("idle.busy", {31'd0, Busy}, 32'd0);
            check("idle.grant", {28'd0, Grant}, 32'd0);
        end
        check("idle.result", {24'd0, Result}, 32'd0);

        // Single request from requester 2
        set_ops(2, 8'hF0, 8'h3C);
        Req = 4'b0100;
        serve("single2", 2, 8'hF0, 8'h3C, 4'b0000);

        // Fairness: the last requester served was 2, so the search order is 3,0,1,2
        set_ops(0, 8'hC3, 8'h81);
        Req = 4'b0101;
        serve("rr0", 0, 8'hC3, 8'h81, 4'b0100);
        serve("rr2", 2, 8'hF0, 8'h3C, 4'b0000);

        // Operand change after capture
        set_ops(0, 8'hFF, 8'h55);
        Req = 4'b0001;
        sb.push_back('{id: 2'd0, res: 8'h55});
        tick();
        A_Bus[0 +: N] = 8'h00;
        check("opchg.grant", {28'd0, Grant}, 32'd1);
        tick();
        check_done("opchg", e);
        Req = 4'b0000;
        tick();
        check("opchg.busy0", {31'd0, Busy}, 32'd0);

        // Reset clears the held result. All four requesters then request together.
        reset = 1'b1;
        tick();
        check("rst2.result", {24'd0, Result}, 32'd0);
        reset = 1'b0;
        set_ops(0, 8'h3E, 8'hF7);
        set_ops(1, 8'hAA, 8'h0F);
        set_ops(2, 8'h96, 8'h5A);
        set_ops(3, 8'h7C, 8'hC6);
        Req = 4'b1111;
        serve("all0", 0, 8'h3E, 8'hF7, 4'b1111);
        serve("all1", 1, 8'hAA, 8'h0F, 4'b1111);
        serve("all2", 2, 8'h96, 8'h5A, 4'b1111);
        serve("all3", 3, 8'h7C, 8'hC6, 4'b1111);
        serve("all0b", 0, 8'h3E, 8'hF7, 4'b0000);
        check("all1.value", {24'd0, 8'hAA & 8'h0F}, 32'h0A);

        // Reset during the EXEC cycle of requester 1
        Req = 4'b0010;
        tick();
        check("abort.grant", {28'd0, Grant}, 32'b0010);
        reset = 1'b1;
        Req   = 4'b0000;
        tick();
        check("abort.grant0", {28'd0, Grant}, 32'd0);
        check("abort.busy0", {31'd0, Busy}, 32'd0);
        check("abort.done0", {31'd0, Done}, 32'd0);
        reset = 1'b0;
        tick();
        check("abort.done1", {31'd0, Done}, 32'd0);
        Req = 4'b0011;
        serve("post0", 0, 8'h3E, 8'hF7, 4'b0010);
        serve("post1", 1, 8'hAA, 8'h0F, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
